// File: rtl/hdmi_packet_pkg.sv
// Shared constants and types for the HDMI data island packet assembler.
// Slot counts, the BCH generator constant, and the subpacket type.
package hdmi_packet_pkg;

    localparam int unsigned PACKET_SLOTS      = 32;
    localparam int unsigned HEADER_DATA_SLOTS = 24;
    localparam int unsigned SUB_DATA_SLOTS    = 28;
    localparam logic [7:0]  BCH_POLY          = 8'h83;

    typedef logic [55:0] subpacket_t;
    typedef logic [4:0]  slot_t;

endpackage

// File: rtl/packet_assembler_if.sv
// Packet-level bus between the packet mux (master) and the assembler (slave).
// Carries the packet contents, the data island window, and the serialised output.
interface packet_assembler_if;
    import hdmi_packet_pkg::*;

    logic                  data_island_period;
    logic [23:0]           header;
    subpacket_t [3:0]      sub;
    logic                  packet_enable;
    logic [8:0]            packet_data;

    modport master (
        output data_island_period,
        output header,
        output sub,
        input  packet_enable,
        input  packet_data
    );

    modport slave (
        input  data_island_period,
        input  header,
        input  sub,
        output packet_enable,
        output packet_data
    );

endinterface

// File: rtl/bch_ecc_step.sv
// One bit-serial step of the HDMI BCH parity LFSR (x^8+x^7+x^6+1).
module bch_ecc_step
    import hdmi_packet_pkg::*;
(
    input  logic [7:0] ecc_in,
    input  logic       data_bit,
    output logic [7:0] ecc_out
);

    logic fb;

    always_comb begin
        fb      = ecc_in[0] ^ data_bit;
        ecc_out = (ecc_in >> 1) ^ (fb ? BCH_POLY : '0);
    end

endmodule

// File: rtl/packet_assembler.sv
// Serialises one data island packet (header + four subpackets) into 32 slots
// of 9 bits each, appending BCH parity computed on the fly.
module packet_assembler
    import hdmi_packet_pkg::*;
(
    input  logic               clk_pixel,
    input  logic               reset,
    packet_assembler_if.slave  pif
);

    slot_t            counter_q, counter_d;
    logic [23:0]      header_q, header_d;
    subpacket_t [3:0] sub_q, sub_d;
    logic [7:0]       hecc_q, hecc_d;
    logic [3:0][7:0]  secc_q, secc_d;
    logic [8:0]       packet_data_q, packet_data_d;

    logic             dip;
    logic             slot0;
    logic             hdr_data;
    logic             sub_data;
    logic [4:0]       hdr_idx;
    logic [4:0]       sub_slot;
    logic [7:0]       hecc_in, hecc_step;
    logic [3:0][7:0]  secc_in, secc_mid, secc_step;
    logic [3:0]       even_bit, odd_bit;
    logic             hdr_bit;
    logic [3:0]       ch1, ch2;

    assign dip = pif.data_island_period;

    // Slot 0 works from the live inputs so the first bits need no extra cycle.
    always_comb begin
        slot0    = dip && (counter_q == '0);
        hdr_data = counter_q < 5'(HEADER_DATA_SLOTS);
        sub_data = counter_q < 5'(SUB_DATA_SLOTS);
        hdr_idx  = hdr_data ? counter_q : '0;
        sub_slot = sub_data ? counter_q : '0;
        header_d = slot0 ? pif.header : header_q;
        sub_d    = slot0 ? pif.sub    : sub_q;
        hecc_in  = (counter_q == '0) ? '0 : hecc_q;
        for (int unsigned k = 0; k < 4; k++) begin
            secc_in[k]  = (counter_q == '0) ? '0 : secc_q[k];
            even_bit[k] = sub_d[k][{sub_slot, 1'b0}];
            odd_bit[k]  = sub_d[k][{sub_slot, 1'b1}];
        end
    end

    bch_ecc_step u_hdr_ecc (
        .ecc_in   (hecc_in),
        .data_bit (header_d[hdr_idx]),
        .ecc_out  (hecc_step)
    );

    for (genvar k = 0; k < 4; k++) begin : g_sub_ecc
        bch_ecc_step u_even (
            .ecc_in   (secc_in[k]),
            .data_bit (even_bit[k]),
            .ecc_out  (secc_mid[k])
        );
        bch_ecc_step u_odd (
            .ecc_in   (secc_mid[k]),
            .data_bit (odd_bit[k]),
            .ecc_out  (secc_step[k])
        );
    end

    // Parity registers freeze once their data slots end; parity slots read the frozen value.
    always_comb begin
        counter_d = dip ? counter_q + 5'd1 : '0;
        hecc_d    = hecc_q;
        secc_d    = secc_q;
        if (!dip) begin
            hecc_d = '0;
            secc_d = '0;
        end else begin
            if (hdr_data) hecc_d = hecc_step;
            if (sub_data) secc_d = secc_step;
        end

        hdr_bit = hdr_data ? header_d[hdr_idx] : hecc_q[counter_q[2:0]];
        for (int unsigned k = 0; k < 4; k++) begin
            ch1[k] = sub_data ? even_bit[k] : secc_q[k][{counter_q[1:0], 1'b0}];
            ch2[k] = sub_data ? odd_bit[k]  : secc_q[k][{counter_q[1:0], 1'b1}];
        end
        packet_data_d = dip ? {ch2, ch1, hdr_bit} : '0;
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            counter_q     <= '0;
            header_q      <= '0;
            sub_q         <= '0;
            hecc_q        <= '0;
            secc_q        <= '0;
            packet_data_q <= '0;
        end else begin
            counter_q     <= counter_d;
            header_q      <= header_d;
            sub_q         <= sub_d;
            hecc_q        <= hecc_d;
            secc_q        <= secc_d;
            packet_data_q <= packet_data_d;
        end
    end

    assign pif.packet_enable = dip && (counter_q == 5'(PACKET_SLOTS - 1));
    assign pif.packet_data   = packet_data_q;

endmodule

// File: tb/tb_packet_assembler.sv
// Directed bench for packet_assembler: compares every output slot against a
// bit-serial reference model plus hand-computed constants.
module tb_packet_assembler;
    import hdmi_packet_pkg::*;

    logic clk_pixel = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [8:0] obs  [32];
    logic [8:0] expw [32];

    always #5 clk_pixel = ~clk_pixel;

    packet_assembler_if pif ();

    packet_assembler dut (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .pif       (pif.slave)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] bch_serial(input logic [63:0] bits, input int unsigned n);
        logic [7:0] e;
        logic       fb;
        e = '0;
        for (int unsigned i = 0; i < n; i++) begin
            fb = e[0] ^ bits[i];
            e  = (e >> 1) ^ (fb ? 8'h83 : 8'h00);
        end
        return e;
    endfunction

    task automatic build_expected(input logic [23:0] h, input subpacket_t [3:0] s);
        logic [7:0] hecc;
        logic [7:0] secc [4];
        hecc = bch_serial({40'b0, h}, 24);
        for (int k = 0; k < 4; k++) secc[k] = bch_serial({8'b0, s[k]}, 56);
        for (int c = 0; c < 32; c++) begin
            expw[c][0] = (c < 24) ? h[c] : hecc[c - 24];
            for (int k = 0; k < 4; k++) begin
                expw[c][1 + k] = (c < 28) ? s[k][2 * c]     : secc[k][2 * (c - 28)];
                expw[c][5 + k] = (c < 28) ? s[k][2 * c + 1] : secc[k][2 * (c - 28) + 1];
            end
        end
    endtask

    task automatic run_packet(input logic [23:0] h, input subpacket_t [3:0] s,
                              input int nslots, input bit scramble, input string name);
        build_expected(h, s);
        for (int c = 0; c < nslots; c++) begin
            pif.data_island_period = 1'b1;
            if (c == 0 || !scramble) begin
                pif.header = h;
                pif.sub    = s;
            end else begin
                pif.header = 24'($urandom);
                for (int k = 0; k < 4; k++) pif.sub[k] = 56'({$urandom, $urandom});
            end
            #1;
            check_eq($sformatf("%s en%0d", name, c), 64'(pif.packet_enable), 64'(c == 31));
            @(posedge clk_pixel);
            #1;
            obs[c] = pif.packet_data;
            check_eq($sformatf("%s d%0d", name, c), 64'(pif.packet_data), 64'(expw[c]));
        end
    endtask

    task automatic idle(input int n, input string name);
        pif.data_island_period = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            check_eq($sformatf("%s en%0d", name, i), 64'(pif.packet_enable), 64'(0));
            @(posedge clk_pixel);
            #1;
            check_eq($sformatf("%s d%0d", name, i), 64'(pif.packet_data), 64'(0));
        end
    endtask

    initial begin
        subpacket_t [3:0] s;
        logic [7:0] hecc_obs;

        reset = 1'b1;
        pif.data_island_period = 1'b0;
        pif.header = '0;
        pif.sub    = '0;
        repeat (2) @(posedge clk_pixel);
        #1;
        check_eq("rst data", 64'(pif.packet_data), 64'(0));
        check_eq("rst en", 64'(pif.packet_enable), 64'(0));
        reset = 1'b0;

        // null packet
        run_packet(24'h0, '0, 32, 1'b0, "null");
        idle(2, "gap0");

        // single header bit: hecc must be 8'h4A
        run_packet(24'h000001, '0, 32, 1'b0, "hdr1");
        check_eq("hdr1 first", 64'(obs[0][0]), 64'(1));
        for (int i = 0; i < 8; i++) hecc_obs[i] = obs[24 + i][0];
        check_eq("hdr1 hecc", 64'(hecc_obs), 64'(8'h4A));
        idle(1, "gap1");

        // each subpacket = 1
        for (int k = 0; k < 4; k++) s[k] = 56'h1;
        run_packet(24'h0, s, 32, 1'b0, "sub1");
        check_eq("sub1 ch1", 64'(obs[0][4:1]), 64'(4'hF));
        check_eq("sub1 ch2", 64'(obs[0][8:5]), 64'(4'h0));
        idle(1, "gap2");

        // three back-to-back packets, inputs scrambled after slot 0
        s[0] = 56'h0123456789ABCD; s[1] = 56'hFEDCBA98765432;
        s[2] = 56'h5A5A5A5A5A5A5A; s[3] = 56'h80000000000001;
        run_packet(24'hABCDEF, s, 32, 1'b1, "b2b0");
        s[0] = 56'hFFFFFFFFFFFFFF; s[1] = 56'h0; s[2] = 56'h13579BDF02468A; s[3] = 56'hC3C3C3C3C3C3C3;
        run_packet(24'h123456, s, 32, 1'b1, "b2b1");
        s[0] = 56'h00000000000080; s[1] = 56'hDEADBEEFCAFE01; s[2] = 56'h1; s[3] = 56'h7FFFFFFFFFFFFF;
        run_packet(24'h800000, s, 32, 1'b1, "b2b2");

        // early deassert at slot 10, fresh packet after 5 idle cycles
        run_packet(24'h00FF00, s, 10, 1'b1, "abt");
        idle(5, "abtgap");
        s[0] = 56'h0F0F0F0F0F0F0F; s[1] = 56'h2; s[2] = 56'h3; s[3] = 56'h4;
        run_packet(24'hC0FFEE, s, 32, 1'b0, "abtnew");

        // reset at slot 15 for 2 cycles, data_island_period held high
        run_packet(24'h0A0A0A, s, 15, 1'b0, "rsta");
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check_eq($sformatf("rst en%0d", i), 64'(pif.packet_enable), 64'(0));
            @(posedge clk_pixel);
            #1;
            check_eq($sformatf("rst d%0d", i), 64'(pif.packet_data), 64'(0));
        end
        reset = 1'b0;
        s[0] = 56'hAAAAAAAAAAAAAA; s[1] = 56'h55555555555555; s[2] = 56'h1; s[3] = 56'h0;
        run_packet(24'h000081, s, 32, 1'b1, "rstnew");
        idle(1, "end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
